spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
SPI Mode 0 target (responder) that emulates a small serial flash for the 6809 SPI flash controller. Used to back the controller with on-FPGA memory and to run controller-to-responder loopback tests. Oversamples SCLK/MOSI/CS on clk and decodes READ 0x03, PAGE PROGRAM 0x02, WREN 0x06, WRDI 0x04 and RDSR 0x05. Holds contents in an internal RAM.

Parameters:
ADDR_W, 12, RAM address width; depth = 2**ADDR_W bytes (4 KB)
PAGE_W, 8, page-program wrap width (256-byte page)

Ports:
clk  in  1  system clock; f_clk >= 8 x f_SCLK
reset  in  1  synchronous, active-low
i_SPI_CLK  in  1  SPI clock from master, idle low
i_SPI_MOSI  in  1  master out, slave in
i_SPI_CS  in  1  chip select, active low
o_SPI_MISO  out  1  serial data to master
o_MISO_OE  out  1  MISO output enable; top level tri-states MISO when 0
o_wr_strobe  out  1  one-clk pulse per byte committed to RAM
o_wr_addr  out  ADDR_W  address of committed byte
o_wr_data  out  8  committed byte
o_wel  out  1  write-enable latch state

Behaviour:
- Reset is clk-synchronous, active-low. Outputs: MISO=0, OE=0, wr_strobe=0, wr_addr=0, wr_data=0, wel=0. State IDLE. RAM contents not cleared.
- i_SPI_CLK, i_SPI_MOSI and i_SPI_CS each pass through a 2-flop synchronizer. Rise/fall detects on synchronized SCLK and CS. MOSI is sampled at detected SCLK rise; MISO is updated at detected SCLK fall.
- MSB first throughout. A 3-bit bit counter counts bits within a byte and resets on CS fall.
- States and transitions:
  - IDLE -> CMD on CS fall.
  - CMD: after 8 bits, decode.
    - 0x03 and 0x02 -> ADDR.
    - 0x05 -> STATUS.
    - 0x06: set wel. 0x04: clear wel. Both -> IGNORE.
    - 0x02 with wel=0 -> IGNORE.
    - Any other opcode -> IGNORE.
  - ADDR: shift 24 bits. Keep the low ADDR_W bits; ignore upper bits. After the 24th bit -> READ (0x03) or WRITE (0x02).
  - READ:
    - RAM read issued on the clk after the 24th-bit rise.
    - On the following SCLK fall, OE=1 and MISO=data[7]. Remaining bits follow on subsequent falls.
    - After a byte's 8th rise, the address increments with wrap at 2**ADDR_W and the next byte is prefetched. Reads are continuous while clocked.
  - WRITE: each 8-bit group is written at the current address.
    - o_wr_strobe pulses for 1 clk with the matching addr/data.
    - Address low PAGE_W bits increment and wrap within the page; upper bits are unchanged.
  - STATUS: shift out {6'b0, wel, busy=0} repeatedly while clocked. OE=1 from the first fall.
  - IGNORE: OE=0 until CS rise.
- CS rise in any state:
  - -> IDLE within 1 clk of the detect; OE=0.
  - A partial byte (fewer than 8 bits) is discarded, with no write.
  - If the transaction was WRITE (any byte count, including 0), wel is cleared.
- CS held high: SCLK/MOSI activity is ignored.
- Reset asserted mid-transaction: immediate IDLE with OE=0 and wel=0. An in-flight byte is lost.
- OE is 0 in IDLE, CMD, ADDR, IGNORE and WRITE.
- Simultaneous CS rise and SCLK rise detect: CS wins and the bit is discarded.

Decomposition:
- Shared package spi_flash_pkg:
  - opcode constants CMD_READ=8'h03, CMD_PP=8'h02, CMD_WREN=8'h06, CMD_WRDI=8'h04, CMD_RDSR=8'h05
  - state enum {IDLE, CMD, ADDR, READ, WRITE, STATUS, IGNORE}
  - status bit indices BUSY=0, WEL=1
- The master controller adopts the same opcode constants.
- One sub-module: spi_resp_ram, a single-port synchronous RAM with 1-clk read latency and byte write, sized 2**ADDR_W x 8, inferred as block RAM.
- Synchronizers and the shift FSM stay in the top.

Test Plan:
- Reset, then RDSR (0x05) with 8 extra clocks -> MISO returns 8'h00; OE high only during the status byte.
- WREN, then CS high, then 0x02 addr 24'h000123 data 8'hA5, 8'h5A, then CS high:
  - wr_strobe pulses with (0x123, A5) and (0x124, 5A).
  - wel reads 1 before the CS rise and 0 after.
- 0x02 without a preceding WREN -> no wr_strobe; a subsequent READ of 0x123 returns the previous contents.
- READ 0x03 addr 24'hFFFFFE for 3 bytes after writing FE=11, FF=22, 000=33 -> MISO returns 11, 22, 33, showing wrap at 4 KB.
- Page wrap: WREN, then 0x02 at 0x1FF with 2 bytes -> writes land at 0x1FF and 0x100.
- Abort cases:
  - CS rise after 5 data bits of a program byte -> no strobe, wel=0.
  - Reset pulse mid-ADDR -> OE=0, and a following RDSR returns 00.
  - Unknown opcode 0x9F -> OE stays 0 for the whole transaction.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - opcodes, FSM states and status bits shared with the flash controller
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_WRDI = 8'h04;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    localparam int BUSY = 0;
    localparam int WEL  = 1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        READ,
        WRITE,
        STATUS,
        IGNORE
    } state_e;

endpackage

// File: rtl/spi_flash_responder_if.sv
// rtl/spi_flash_responder_if.sv - SPI pin bundle between flash controller and responder
interface spi_flash_responder_if;

    logic i_SPI_CLK;
    logic i_SPI_MOSI;
    logic i_SPI_CS;
    logic o_SPI_MISO;
    logic o_MISO_OE;

    modport master (
        output i_SPI_CLK,
        output i_SPI_MOSI,
        output i_SPI_CS,
        input  o_SPI_MISO,
        input  o_MISO_OE
    );

    modport slave (
        input  i_SPI_CLK,
        input  i_SPI_MOSI,
        input  i_SPI_CS,
        output o_SPI_MISO,
        output o_MISO_OE
    );

endinterface

// File: rtl/spi_resp_ram.sv
// rtl/spi_resp_ram.sv - single-port byte RAM, one-clock read latency, block-RAM style
module spi_resp_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode 0 serial-flash responder backed by on-chip RAM
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int PAGE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    spi_flash_responder_if.slave spi,
    output logic              o_wr_strobe,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_wel
);

    logic [1:0] sclk_sync, mosi_sync, cs_sync;
    logic       sclk_d, cs_d;
    logic       sclk_s, mosi_s, cs_s;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

    // CS sync resets low so a chip select still held low across reset never looks like a fall
    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            cs_sync   <= 2'b00;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi.i_SPI_CLK};
            mosi_sync <= {mosi_sync[0], spi.i_SPI_MOSI};
            cs_sync   <= {cs_sync[0], spi.i_SPI_CS};
            sclk_d    <= sclk_sync[1];
            cs_d      <= cs_sync[1];
        end
    end

    assign sclk_s    = sclk_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign cs_s      = cs_sync[1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    state_e            state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_in;
    logic [1:0]        addr_byte;
    logic [ADDR_W-1:0] addr;
    logic              is_read;
    logic [7:0]        tx_sr;
    logic              rd_req, rd_load;
    logic              miso, oe;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wel;

    logic [7:0]        rx_byte;
    logic              byte_done;
    logic [ADDR_W-1:0] addr_shift, addr_inc, addr_page_inc;
    logic [PAGE_W-1:0] page_lo;
    logic [7:0]        status_byte;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_rdata;

    assign rx_byte    = {shift_in[6:0], mosi_s};
    assign byte_done  = sclk_rise && (bit_cnt == 3'd7);
    assign addr_shift = {addr[ADDR_W-2:0], mosi_s};
    assign addr_inc   = addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign page_lo    = addr[PAGE_W-1:0] + {{(PAGE_W-1){1'b0}}, 1'b1};

    // page program wraps inside the page; upper address bits never move
    always_comb begin
        addr_page_inc              = addr;
        addr_page_inc[PAGE_W-1:0]  = page_lo;
        status_byte                = 8'h00;
        status_byte[WEL]           = wel;
        status_byte[BUSY]          = 1'b0;
    end

    assign ram_addr = wr_strobe ? wr_addr : addr;

    spi_resp_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .en    (rd_req),
        .we    (wr_strobe),
        .addr  (ram_addr),
        .wdata (wr_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift_in  <= 8'h00;
            addr_byte <= 2'd0;
            addr      <= '0;
            is_read   <= 1'b0;
            tx_sr     <= 8'h00;
            rd_req    <= 1'b0;
            rd_load   <= 1'b0;
            miso      <= 1'b0;
            oe        <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
            wel       <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            rd_req    <= 1'b0;
            rd_load   <= rd_req;
            if (rd_load) begin
                tx_sr <= ram_rdata;
            end

            // CS rise outranks any SCLK edge seen in the same clock
            if (cs_rise) begin
                state <= IDLE;
                oe    <= 1'b0;
                miso  <= 1'b0;
                if (state == WRITE) begin
                    wel <= 1'b0;
                end
            end else if (cs_fall) begin
                state     <= CMD;
                bit_cnt   <= 3'd0;
                addr_byte <= 2'd0;
                oe        <= 1'b0;
            end else if (state != IDLE) begin
                if (sclk_rise) begin
                    shift_in <= rx_byte;
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (sclk_fall && (state == READ || state == STATUS)) begin
                    oe    <= 1'b1;
                    miso  <= tx_sr[7];
                    tx_sr <= {tx_sr[6:0], 1'b0};
                end

                case (state)
                    CMD: begin
                        if (byte_done) begin
                            case (rx_byte)
                                CMD_READ: begin
                                    state   <= ADDR;
                                    is_read <= 1'b1;
                                end
                                CMD_PP: begin
                                    state   <= wel ? ADDR : IGNORE;
                                    is_read <= 1'b0;
                                end
                                CMD_WREN: begin
                                    wel   <= 1'b1;
                                    state <= IGNORE;
                                end
                                CMD_WRDI: begin
                                    wel   <= 1'b0;
                                    state <= IGNORE;
                                end
                                CMD_RDSR: begin
                                    state <= STATUS;
                                    tx_sr <= status_byte;
                                end
                                default: state <= IGNORE;
                            endcase
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            addr <= addr_shift;
                        end
                        if (byte_done) begin
                            addr_byte <= addr_byte + 2'd1;
                            if (addr_byte == 2'd2) begin
                                state  <= is_read ? READ : WRITE;
                                rd_req <= is_read;
                            end
                        end
                    end
                    READ: begin
                        if (byte_done) begin
                            addr   <= addr_inc;
                            rd_req <= 1'b1;
                        end
                    end
                    WRITE: begin
                        if (byte_done) begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr;
                            wr_data   <= rx_byte;
                            addr      <= addr_page_inc;
                        end
                    end
                    STATUS: begin
                        if (byte_done) begin
                            tx_sr <= status_byte;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign spi.o_SPI_MISO = miso;
    assign spi.o_MISO_OE  = oe;
    assign o_wr_strobe    = wr_strobe;
    assign o_wr_addr      = wr_addr;
    assign o_wr_data      = wr_data;
    assign o_wel          = wel;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - transaction table and corner sequences for spi_flash_responder
`timescale 1ns/1ps
module tb_spi_flash_responder;
    import spi_flash_pkg::*;

    localparam int AW = 12;
    localparam int HALF = 6;

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          n;
        logic [23:0] data;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_strobe;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wel;
    int            total = 0;
    int            bad = 0;

    logic [7:0]    m_mem [4096];
    logic          m_wel = 1'b0;
    logic [19:0]   wr_q[$];
    logic [7:0]    rd_q[$];
    txn_t          tbl [19];

    spi_flash_responder_if bus();

    spi_flash_responder #(.ADDR_W(AW), .PAGE_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi         (bus),
        .o_wr_strobe (wr_strobe),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_wel       (wel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && wr_strobe) begin
            if (wr_q.size() == 0) begin
                check("unexpected_wr_strobe", {wr_addr, wr_data}, 32'hFFFFFFFF);
            end else begin
                check("wr_addr_data", {wr_addr, wr_data}, wr_q.pop_front());
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int nb,
                             output logic [7:0] rx, output logic oe_all, output logic oe_any);
        rx = 8'h00;
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int i = 0; i < nb; i++) begin
            bus.i_SPI_MOSI = tx[7-i];
            wait_clks(HALF);
            rx[7-i] = bus.o_SPI_MISO;
            oe_all &= bus.o_MISO_OE;
            oe_any |= bus.o_MISO_OE;
            bus.i_SPI_CLK = 1'b1;
            wait_clks(HALF);
            bus.i_SPI_CLK = 1'b0;
        end
    endtask

    task automatic run_txn(input txn_t t);
        logic [7:0]    rx, d;
        logic          oa, on, do_write, exp_oe;
        logic [AW-1:0] a;
        bus.i_SPI_CS = 1'b0;
        wait_clks(HALF);
        xfer_bits(t.cmd, 8, rx, oa, on);
        check("cmd_oe", on, 0);
        if (t.cmd == CMD_WREN) m_wel = 1'b1;
        if (t.cmd == CMD_WRDI) m_wel = 1'b0;
        do_write = (t.cmd == CMD_PP) && m_wel;
        exp_oe = (t.cmd == CMD_READ) || (t.cmd == CMD_RDSR);
        a = t.addr[AW-1:0];
        if (t.cmd == CMD_READ || t.cmd == CMD_PP) begin
            for (int k = 0; k < 3; k++) begin
                xfer_bits(t.addr[23-8*k -: 8], 8, rx, oa, on);
                check("addr_oe", on, 0);
            end
        end
        for (int k = 0; k < t.n; k++) begin
            d = (t.cmd == CMD_PP) ? t.data[23-8*k -: 8] : 8'h00;
            if (do_write) begin
                wr_q.push_back({a, d});
                m_mem[a] = d;
                a = {a[AW-1:8], a[7:0] + 8'd1};
            end
            if (t.cmd == CMD_READ) begin
                rd_q.push_back(m_mem[a]);
                a = a + 12'd1;
            end
            if (t.cmd == CMD_RDSR) rd_q.push_back({6'b0, m_wel, 1'b0});
            xfer_bits(d, 8, rx, oa, on);
            if (exp_oe) check("data_oe_high", oa, 1);
            else        check("data_oe_low", on, 0);
            if (rd_q.size() > 0) check("miso_byte", rx, rd_q.pop_front());
        end
        wait_clks(HALF);
        if (do_write) check("wel_before_cs_rise", wel, 1);
        bus.i_SPI_CS = 1'b1;
        wait_clks(8);
        if (do_write) m_wel = 1'b0;
        check("wel_after_txn", wel, m_wel);
        check("oe_after_cs_rise", bus.o_MISO_OE, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [7:0] rx;
        logic       oa, on;

        tbl[0]  = '{CMD_RDSR, 24'h000000, 1, 24'h000000};
        tbl[1]  = '{CMD_WREN, 24'h000000, 0, 24'h000000};
        tbl[2]  = '{CMD_PP,   24'h000123, 2, 24'hA55A00};
        tbl[3]  = '{CMD_PP,   24'h000123, 1, 24'h770000};
        tbl[4]  = '{CMD_READ, 24'h000123, 2, 24'h000000};
        tbl[5]  = '{CMD_WREN, 24'h000000, 0, 24'h000000};
        tbl[6]  = '{CMD_PP,   24'hFFFFFE, 2, 24'h112200};
        tbl[7]  = '{CMD_WREN, 24'h000000, 0, 24'h000000};
        tbl[8]  = '{CMD_PP,   24'h000000, 1, 24'h330000};
        tbl[9]  = '{CMD_READ, 24'hFFFFFE, 3, 24'h000000};
        tbl[10] = '{CMD_WREN, 24'h000000, 0, 24'h000000};
        tbl[11] = '{CMD_PP,   24'h0001FF, 2, 24'hAABB00};
        tbl[12] = '{CMD_READ, 24'h0001FF, 1, 24'h000000};
        tbl[13] = '{CMD_READ, 24'h000100, 1, 24'h000000};
        tbl[14] = '{CMD_WREN, 24'h000000, 0, 24'h000000};
        tbl[15] = '{CMD_RDSR, 24'h000000, 2, 24'h000000};
        tbl[16] = '{CMD_WRDI, 24'h000000, 0, 24'h000000};
        tbl[17] = '{CMD_RDSR, 24'h000000, 1, 24'h000000};
        tbl[18] = '{8'h9F,    24'h000000, 2, 24'h000000};

        bus.i_SPI_CLK  = 1'b0;
        bus.i_SPI_MOSI = 1'b0;
        bus.i_SPI_CS   = 1'b1;
        wait_clks(5);
        check("rst_miso", bus.o_SPI_MISO, 0);
        check("rst_oe", bus.o_MISO_OE, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_wel", wel, 0);
        reset = 1'b1;
        wait_clks(8);

        for (int i = 0; i < 19; i++) begin
            run_txn(tbl[i]);
        end

        // program byte cut off after 5 bits: nothing written, latch dropped
        run_txn('{CMD_WREN, 24'h000000, 0, 24'h000000});
        bus.i_SPI_CS = 1'b0;
        wait_clks(HALF);
        xfer_bits(CMD_PP, 8, rx, oa, on);
        xfer_bits(8'h00, 8, rx, oa, on);
        xfer_bits(8'h00, 8, rx, oa, on);
        xfer_bits(8'h50, 8, rx, oa, on);
        xfer_bits(8'hC3, 5, rx, oa, on);
        wait_clks(HALF);
        bus.i_SPI_CS = 1'b1;
        wait_clks(8);
        m_wel = 1'b0;
        check("partial_byte_wel", wel, 0);

        // reset pulse in the middle of the address phase
        run_txn('{CMD_WREN, 24'h000000, 0, 24'h000000});
        bus.i_SPI_CS = 1'b0;
        wait_clks(HALF);
        xfer_bits(CMD_READ, 8, rx, oa, on);
        xfer_bits(8'h00, 8, rx, oa, on);
        reset = 1'b0;
        wait_clks(2);
        check("midaddr_reset_oe", bus.o_MISO_OE, 0);
        check("midaddr_reset_wel", wel, 0);
        reset = 1'b1;
        m_wel = 1'b0;
        wait_clks(4);
        bus.i_SPI_CS = 1'b1;
        wait_clks(8);
        run_txn('{CMD_RDSR, 24'h000000, 1, 24'h000000});

        wait_clks(10);
        check("wr_queue_drained", wr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
